branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- EX-stage branch resolution unit; the consumer end of the fetch-time branch predictor.
- Carries each fetch-time prediction (taken flag, target) alongside its instruction through DEC into EX.
- Evaluates the real condition in EX, detects mispredictions, and issues a registered front-end redirect/flush.
- Drives the registered update bus (branch_ex, branch_taken_ex, branch_pc_ex, branch_target_pc) back to the predictor tables.

Parameters:
ADDR_WIDTH, 32, instruction address width
DATA_WIDTH, 32, operand width

Ports:
cpu_clk  in  1  core clock
cpu_rstn  in  1  asynchronous active-low reset
valid_if  in  1  instruction in IF advances to DEC this cycle
pc_if  in  ADDR_WIDTH  PC of IF instruction
predict_taken_if  in  1  predictor taken flag for IF instruction
predict_target_pc_if  in  ADDR_WIDTH  predicted target for IF instruction
stall_dec  in  1  hold DEC register
stall_ex  in  1  hold EX register; no resolution this cycle
flush_exc  in  1  exception/trap flush, highest priority
branch_valid_ex  in  1  EX holds a conditional branch
funct3_ex  in  3  branch condition code
src_data1_ex  in  DATA_WIDTH  rs1 operand
src_data2_ex  in  DATA_WIDTH  rs2 operand
target_pc_ex  in  ADDR_WIDTH  computed pc+imm
redirect_valid  out  1  one-cycle front-end redirect and flush of IF/DEC
redirect_pc  out  ADDR_WIDTH  correct fetch address
branch_ex  out  1  predictor update strobe
branch_taken_ex  out  1  actual outcome
branch_pc_ex  out  ADDR_WIDTH  branch PC
branch_target_pc  out  ADDR_WIDTH  actual taken target

Behaviour:
- Reset: all outputs 0; shadow valid bits 0; FSM in RUN.
- Shadow pipe, DEC stage: {valid, pc, ptaken, ptarget}.
  - Loads from the IF inputs when !stall_dec.
  - Valid bit = valid_if.
  - Holds when stall_dec.
- Shadow pipe, EX stage:
  - Loads from the DEC shadow when !stall_ex.
  - Takes valid=0 when stall_dec && !stall_ex (bubble).
- Condition decode by funct3:
  - 000 eq, 001 ne: equality compare.
  - 100 lt, 101 ge: signed compare.
  - 110 ltu, 111 geu: unsigned compare.
  - 010 and 011: not taken, no update.
- Resolve: fires when ex_shadow_valid && branch_valid_ex && !stall_ex && state==RUN.
- Mispredict when either holds:
  - actual taken != ptaken, or
  - both taken and target_pc_ex != ptarget.
- redirect_pc:
  - actual taken: target_pc_ex.
  - actual not taken: pc+4, modulo 2^ADDR_WIDTH.
- Latency: resolve in cycle N gives registered outputs in N+1.
  - branch_ex is high for exactly 1 cycle.
  - redirect_valid is high for exactly 1 cycle, only on a mispredict.
- FSM states and transitions:
  - RUN: on a mispredict resolve, go to SQUASH.
  - SQUASH (the N+1 cycle): both shadow valid bits clear; EX content is treated as wrong-path, so no resolve and no update; return to RUN.
- A correctly predicted branch produces an update only and stays in RUN.
- flush_exc:
  - Clears both shadow valids the same cycle.
  - Suppresses resolve, update and redirect that cycle.
  - Forces RUN.
  - Wins over a simultaneous mispredict.
- Stall:
  - stall_ex freezes the EX shadow and blocks resolve.
  - A registered redirect already in flight still completes its 1 cycle.
- Reset asserted mid-SQUASH: immediate return to RUN with outputs 0.
- Non-branch EX instructions are ignored, even when the shadow predicted taken.
  - Aliased BHT hits on non-branches are left to the fetch unit.

Optional Feature:
BRANCH_PERF_CNT_EN
- Defined: adds 32-bit saturating output counters.
  - br_total_cnt: +1 per resolve.
  - br_mispred_cnt: +1 per mispredict.
  - Both reset to 0.
  - Both hold at 0xFFFFFFFF.
  - Neither counts in SQUASH or on flush_exc.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Resolve BEQ, src1=src2=5, ptaken=1, ptarget=0x100=target_pc_ex, pc=0x80 -> next cycle: branch_ex=1, taken=1, target=0x100, redirect_valid=0.
- Resolve BNE, src1=src2, ptaken=1, pc=0x200 -> next cycle: redirect_valid=1, redirect_pc=0x204, branch_taken_ex=0; the following cycle's EX branch is not resolved.
- Resolve BLT, src1=0xFFFFFFFF, src2=1, ptaken=0, target 0x40 -> redirect to 0x40. Same operands with BLTU -> not taken, no redirect.
- Taken both ways, ptarget=0x300, target_pc_ex=0x340 -> redirect_valid=1, redirect_pc=0x340.
- Mispredict and flush_exc in the same cycle -> no redirect, no update, shadow valids 0.
- Hold stall_ex 3 cycles with a branch in EX -> no output until the stall drops, then a single update. Reset mid-SQUASH -> all outputs 0. With BRANCH_PERF_CNT_EN, after the first four scenarios -> total=4, mispred=3.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution unit.
// Carries each fetch-time prediction (taken flag, target) through DEC into EX
// alongside its instruction, evaluates the real branch condition in EX, and
// drives a registered predictor update bus plus a one-cycle front-end
// redirect/flush whenever the prediction was wrong.
// Optional build macro: BRANCH_PERF_CNT_EN adds saturating resolve and
// mispredict counters (br_total_cnt, br_mispred_cnt).
module branch_resolve #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  valid_if,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    input  logic                  predict_taken_if,
    input  logic [ADDR_WIDTH-1:0] predict_target_pc_if,
    input  logic                  stall_dec,
    input  logic                  stall_ex,
    input  logic                  flush_exc,
    input  logic                  branch_valid_ex,
    input  logic [2:0]            funct3_ex,
    input  logic [DATA_WIDTH-1:0] src_data1_ex,
    input  logic [DATA_WIDTH-1:0] src_data2_ex,
    input  logic [ADDR_WIDTH-1:0] target_pc_ex,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  branch_ex,
    output logic                  branch_taken_ex,
    output logic [ADDR_WIDTH-1:0] branch_pc_ex,
    output logic [ADDR_WIDTH-1:0] branch_target_pc
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]           br_total_cnt,
    output logic [31:0]           br_mispred_cnt
`endif
);

    // RUN: normal resolution. SQUASH: the cycle the redirect is visible;
    // everything still in the shadow pipe is wrong-path.
    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t state, state_next;

    // DEC-stage prediction shadow
    logic                  dec_valid;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic                  dec_ptaken;
    logic [ADDR_WIDTH-1:0] dec_ptarget;

    // EX-stage prediction shadow
    logic                  ex_valid;
    logic [ADDR_WIDTH-1:0] ex_pc;
    logic                  ex_ptaken;
    logic [ADDR_WIDTH-1:0] ex_ptarget;

    logic                  cond_known;
    logic                  actual_taken;
    logic                  resolve;
    logic                  mispredict;
    logic                  squash_now;
    logic [ADDR_WIDTH-1:0] fallthrough_pc;

    // Decode funct3 into the actual branch outcome.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cond_known   = 1'b1;
        actual_taken = 1'b0;
        case (funct3_ex)
            3'b000:  actual_taken = (src_data1_ex == src_data2_ex);
            3'b001:  actual_taken = (src_data1_ex != src_data2_ex);
            3'b100:  actual_taken = ($signed(src_data1_ex) <  $signed(src_data2_ex));
            3'b101:  actual_taken = ($signed(src_data1_ex) >= $signed(src_data2_ex));
            3'b110:  actual_taken = (src_data1_ex <  src_data2_ex);
            3'b111:  actual_taken = (src_data1_ex >= src_data2_ex);
            default: cond_known   = 1'b0;
        endcase
    end

    assign squash_now     = (state == SQUASH);
    assign resolve        = ex_valid && branch_valid_ex && cond_known &&
                            !stall_ex && !squash_now && !flush_exc;
    assign mispredict     = resolve &&
                            ((actual_taken != ex_ptaken) ||
                             (actual_taken && (target_pc_ex != ex_ptarget)));
    assign fallthrough_pc = ex_pc + ADDR_WIDTH'(4);

    // Next-state logic; an exception flush always lands in RUN.
    always_comb begin
        state_next = state;
        case (state)
            RUN:    if (mispredict) state_next = SQUASH;
            SQUASH: state_next = RUN;
        endcase
        if (flush_exc) state_next = RUN;
    end

    // State register.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!cpu_rstn) state <= RUN;
        else           state <= state_next;
    end

    // DEC shadow: follows IF unless stalled; killed by flush or squash.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            dec_valid   <= 1'b0;
            dec_pc      <= '0;
            dec_ptaken  <= 1'b0;
            dec_ptarget <= '0;
        end else begin
            if (flush_exc || squash_now) dec_valid <= 1'b0;
            else if (!stall_dec)         dec_valid <= valid_if;
            if (!stall_dec) begin
                dec_pc      <= pc_if;
                dec_ptaken  <= predict_taken_if;
                dec_ptarget <= predict_target_pc_if;
            end
        end
    end

    // EX shadow: follows DEC unless stalled; a held DEC inserts a bubble.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_ptaken  <= 1'b0;
            ex_ptarget <= '0;
        end else begin
            if (flush_exc || squash_now) ex_valid <= 1'b0;
            else if (!stall_ex)          ex_valid <= dec_valid && !stall_dec;
            if (!stall_ex) begin
                ex_pc      <= dec_pc;
                ex_ptaken  <= dec_ptaken;
                ex_ptarget <= dec_ptarget;
            end
        end
    end

    // Registered update bus and redirect; strobes are single-cycle pulses.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            branch_ex        <= 1'b0;
            branch_taken_ex  <= 1'b0;
            branch_pc_ex     <= '0;
            branch_target_pc <= '0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
        end else begin
            branch_ex      <= resolve;
            redirect_valid <= mispredict;
            if (resolve) begin
                branch_taken_ex  <= actual_taken;
                branch_pc_ex     <= ex_pc;
                branch_target_pc <= target_pc_ex;
            end
            if (mispredict) begin
                redirect_pc <= actual_taken ? target_pc_ex : fallthrough_pc;
            end
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    // Saturating resolve / mispredict counters.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            br_total_cnt   <= '0;
            br_mispred_cnt <= '0;
        end else begin
            if (resolve && (br_total_cnt != 32'hFFFF_FFFF))
                br_total_cnt <= br_total_cnt + 32'd1;
            if (mispredict && (br_mispred_cnt != 32'hFFFF_FFFF))
                br_mispred_cnt <= br_mispred_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the prediction pipeline.
module tb_branch_resolve;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b0;
    logic        valid_if = 1'b0;
    logic [31:0] pc_if = '0;
    logic        predict_taken_if = 1'b0;
    logic [31:0] predict_target_pc_if = '0;
    logic        stall_dec = 1'b0;
    logic        stall_ex = 1'b0;
    logic        flush_exc = 1'b0;
    logic        branch_valid_ex = 1'b0;
    logic [2:0]  funct3_ex = '0;
    logic [31:0] src_data1_ex = '0;
    logic [31:0] src_data2_ex = '0;
    logic [31:0] target_pc_ex = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        branch_ex;
    logic        branch_taken_ex;
    logic [31:0] branch_pc_ex;
    logic [31:0] branch_target_pc;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] br_total_cnt;
    logic [31:0] br_mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolve #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .cpu_clk              (cpu_clk),
        .cpu_rstn             (cpu_rstn),
        .valid_if             (valid_if),
        .pc_if                (pc_if),
        .predict_taken_if     (predict_taken_if),
        .predict_target_pc_if (predict_target_pc_if),
        .stall_dec            (stall_dec),
        .stall_ex             (stall_ex),
        .flush_exc            (flush_exc),
        .branch_valid_ex      (branch_valid_ex),
        .funct3_ex            (funct3_ex),
        .src_data1_ex         (src_data1_ex),
        .src_data2_ex         (src_data2_ex),
        .target_pc_ex         (target_pc_ex),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .branch_ex            (branch_ex),
        .branch_taken_ex      (branch_taken_ex),
        .branch_pc_ex         (branch_pc_ex),
        .branch_target_pc     (branch_target_pc)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .br_total_cnt         (br_total_cnt),
        .br_mispred_cnt       (br_mispred_cnt)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] ptgt;
    } slot_t;

    function automatic bit is_cond_code(input logic [2:0] f);
        return !(f == 3'd2 || f == 3'd3);
    endfunction

    function automatic bit outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int signed   sa = a;
        int signed   sb = b;
        int unsigned ua = a;
        int unsigned ub = b;
        case (f)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    slot_t       m_dec = '{v: 0, pc: 0, pt: 0, ptgt: 0};
    slot_t       m_ex  = '{v: 0, pc: 0, pt: 0, ptgt: 0};
    bit          m_wrong_path = 0;   // redirect cycle: EX is wrong-path
    bit          e_branch = 0, e_taken = 0, e_redirect = 0;
    logic [31:0] e_pc = '0, e_tgt = '0, e_rpc = '0;
    longint      e_total = 0, e_mis = 0;

    always @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            m_dec = '{v: 0, pc: 0, pt: 0, ptgt: 0};
            m_ex  = '{v: 0, pc: 0, pt: 0, ptgt: 0};
            m_wrong_path = 0;
            e_branch = 0; e_taken = 0; e_redirect = 0;
            e_pc = 0; e_tgt = 0; e_rpc = 0;
            e_total = 0; e_mis = 0;
        end else begin
            bit act, res, mis;
            slot_t old_dec;
            act = outcome(funct3_ex, src_data1_ex, src_data2_ex);
            res = m_ex.v && branch_valid_ex && is_cond_code(funct3_ex) &&
                  !stall_ex && !m_wrong_path && !flush_exc;
            mis = res && ((act != m_ex.pt) || (act && target_pc_ex != m_ex.ptgt));
            e_branch   = res;
            e_redirect = mis;
            if (res) begin
                e_taken = act; e_pc = m_ex.pc; e_tgt = target_pc_ex;
                if (e_total < 64'hFFFF_FFFF) e_total++;
            end
            if (mis) begin
                e_rpc = act ? target_pc_ex : m_ex.pc + 32'd4;
                if (e_mis < 64'hFFFF_FFFF) e_mis++;
            end
            old_dec = m_dec;
            if (!stall_ex) begin
                m_ex = old_dec;
                if (stall_dec) m_ex.v = 0;
            end
            if (!stall_dec) m_dec = '{v: valid_if, pc: pc_if, pt: predict_taken_if, ptgt: predict_target_pc_if};
            if (flush_exc || m_wrong_path) begin
                m_dec.v = 0;
                m_ex.v  = 0;
            end
            m_wrong_path = mis;
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge cpu_clk) begin
        check("branch_ex", {63'd0, branch_ex}, {63'd0, e_branch});
        check("redirect_valid", {63'd0, redirect_valid}, {63'd0, e_redirect});
        if (e_redirect) check("redirect_pc", {32'd0, redirect_pc}, {32'd0, e_rpc});
        if (e_branch) begin
            check("branch_taken_ex", {63'd0, branch_taken_ex}, {63'd0, e_taken});
            check("branch_pc_ex", {32'd0, branch_pc_ex}, {32'd0, e_pc});
            check("branch_target_pc", {32'd0, branch_target_pc}, {32'd0, e_tgt});
        end
`ifdef BRANCH_PERF_CNT_EN
        check("br_total_cnt", {32'd0, br_total_cnt}, e_total);
        check("br_mispred_cnt", {32'd0, br_mispred_cnt}, e_mis);
`endif
    end

    // ---------------- directed stimulus helper ----------------
    // Idle cycle, branch enters IF, a not-taken-predicted trailer follows,
    // branch resolves in EX (optionally stalled / flushed). Returns #1 after
    // the edge that registers the resolution.
    task automatic run_branch(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] tgt, input bit flush, input int nstall);
        valid_if = 0; branch_valid_ex = 0; flush_exc = 0; stall_ex = 0; stall_dec = 0;
        @(posedge cpu_clk); #1;
        valid_if = 1; pc_if = pc; predict_taken_if = pt; predict_target_pc_if = ptgt;
        @(posedge cpu_clk); #1;
        pc_if = pc + 32'd4; predict_taken_if = 0; predict_target_pc_if = 0;
        @(posedge cpu_clk); #1;
        valid_if = 0; branch_valid_ex = 1; funct3_ex = f3;
        src_data1_ex = a; src_data2_ex = b; target_pc_ex = tgt; flush_exc = flush;
        for (int i = 0; i < nstall; i++) begin
            stall_ex = 1; stall_dec = 1;
            @(posedge cpu_clk); #1;
            check("stall_no_update", {63'd0, branch_ex}, 64'd0);
        end
        stall_ex = 0; stall_dec = 0;
        @(posedge cpu_clk); #1;
        branch_valid_ex = 0; flush_exc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [4];
        logic [31:0] tgts [3];
        vals = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF};
        tgts = '{32'h100, 32'h200, 32'h300};

        repeat (3) @(posedge cpu_clk);
        #1;
        check("reset_branch_ex", {63'd0, branch_ex}, 64'd0);
        check("reset_redirect", {63'd0, redirect_valid}, 64'd0);
        check("reset_redirect_pc", {32'd0, redirect_pc}, 64'd0);
        cpu_rstn = 1;

        // Correctly predicted taken BEQ: update only.
        run_branch(32'h80, 1, 32'h100, 3'd0, 32'd5, 32'd5, 32'h100, 0, 0);
        check("beq_branch_ex", {63'd0, branch_ex}, 64'd1);
        check("beq_taken", {63'd0, branch_taken_ex}, 64'd1);
        check("beq_target", {32'd0, branch_target_pc}, 64'h100);
        check("beq_pc", {32'd0, branch_pc_ex}, 64'h80);
        check("beq_no_redirect", {63'd0, redirect_valid}, 64'd0);

        // BNE predicted taken but not taken: redirect to fall-through.
        run_branch(32'h200, 1, 32'h260, 3'd1, 32'd7, 32'd7, 32'h260, 0, 0);
        check("bne_redirect", {63'd0, redirect_valid}, 64'd1);
        check("bne_redirect_pc", {32'd0, redirect_pc}, 64'h204);
        check("bne_taken", {63'd0, branch_taken_ex}, 64'd0);
        check("bne_update", {63'd0, branch_ex}, 64'd1);
        // Trailer is in EX during the squash cycle and must be ignored.
        branch_valid_ex = 1; funct3_ex = 3'd0; src_data1_ex = 1; src_data2_ex = 1;
        @(posedge cpu_clk); #1;
        branch_valid_ex = 0;
        check("squash_no_update", {63'd0, branch_ex}, 64'd0);
        check("squash_no_redirect", {63'd0, redirect_valid}, 64'd0);

        // BLT signed: -1 < 1 taken, predicted not taken.
        run_branch(32'h300, 0, 32'h0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 0);
        check("blt_redirect", {63'd0, redirect_valid}, 64'd1);
        check("blt_redirect_pc", {32'd0, redirect_pc}, 64'h40);

        // Taken both ways, wrong target.
        run_branch(32'h180, 1, 32'h300, 3'd0, 32'd9, 32'd9, 32'h340, 0, 0);
        check("tgt_redirect", {63'd0, redirect_valid}, 64'd1);
        check("tgt_redirect_pc", {32'd0, redirect_pc}, 64'h340);
`ifdef BRANCH_PERF_CNT_EN
        check("perf_total_4", {32'd0, br_total_cnt}, 64'd4);
        check("perf_mispred_3", {32'd0, br_mispred_cnt}, 64'd3);
`endif

        // BLTU with the same operands: not taken, correctly predicted.
        run_branch(32'h300, 0, 32'h0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 0);
        check("bltu_update", {63'd0, branch_ex}, 64'd1);
        check("bltu_taken", {63'd0, branch_taken_ex}, 64'd0);
        check("bltu_no_redirect", {63'd0, redirect_valid}, 64'd0);

        // Mispredict coinciding with an exception flush.
        run_branch(32'h400, 0, 32'h0, 3'd0, 32'd3, 32'd3, 32'h500, 1, 0);
        check("flush_no_update", {63'd0, branch_ex}, 64'd0);
        check("flush_no_redirect", {63'd0, redirect_valid}, 64'd0);
        branch_valid_ex = 1; funct3_ex = 3'd0; src_data1_ex = 2; src_data2_ex = 2;
        @(posedge cpu_clk); #1;
        branch_valid_ex = 0;
        check("flush_ex_cleared", {63'd0, branch_ex}, 64'd0);

        // Branch held in EX for three stall cycles, then one update.
        run_branch(32'h500, 1, 32'h600, 3'd0, 32'd4, 32'd4, 32'h600, 0, 3);
        check("stall_release_update", {63'd0, branch_ex}, 64'd1);
        check("stall_release_pc", {32'd0, branch_pc_ex}, 64'h500);
        @(posedge cpu_clk); #1;
        check("stall_single_update", {63'd0, branch_ex}, 64'd0);

        // Reset asserted during the squash cycle.
        run_branch(32'h700, 1, 32'h760, 3'd1, 32'd1, 32'd1, 32'h760, 0, 0);
        check("pre_reset_redirect", {63'd0, redirect_valid}, 64'd1);
        cpu_rstn = 0;
        #1;
        check("midsquash_rst_redirect", {63'd0, redirect_valid}, 64'd0);
        check("midsquash_rst_branch", {63'd0, branch_ex}, 64'd0);
        check("midsquash_rst_rpc", {32'd0, redirect_pc}, 64'd0);
        @(posedge cpu_clk); #1;
        cpu_rstn = 1;

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge cpu_clk); #1;
            valid_if             = ($urandom_range(0, 3) != 0);
            pc_if                = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            predict_taken_if     = 1'($urandom_range(0, 1));
            predict_target_pc_if = tgts[$urandom_range(0, 2)];
            stall_dec            = ($urandom_range(0, 7) == 0);
            stall_ex             = ($urandom_range(0, 9) == 0);
            flush_exc            = ($urandom_range(0, 31) == 0);
            branch_valid_ex      = ($urandom_range(0, 2) != 0);
            funct3_ex            = 3'($urandom_range(0, 7));
            src_data1_ex         = vals[$urandom_range(0, 3)];
            src_data2_ex         = vals[$urandom_range(0, 3)];
            target_pc_ex         = tgts[$urandom_range(0, 2)];
        end
        valid_if = 0; branch_valid_ex = 0; stall_dec = 0; stall_ex = 0; flush_exc = 0;
        repeat (3) @(posedge cpu_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
